// File: rtl/vmc_pkg.sv
// rtl/vmc_pkg.sv - shared encodings and preset timing tables for the video mode controller
package vmc_pkg;

    localparam int VMC_WIDTH  = 11;
    localparam int NUM_FIELDS = 8;

    // Requested/current video mode encodings
    typedef enum logic [1:0] {
        MODE_640X480 = 2'd0,
        MODE_800X600 = 2'd1,
        MODE_640X400 = 2'd2,
        MODE_CUSTOM  = 2'd3
    } mode_e;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_SETTLE  = 2'd2
    } state_e;

    // Field index inside a timing set; also the custom register addresses
    localparam logic [2:0] CFG_H_SYNC   = 3'd0;
    localparam logic [2:0] CFG_H_FRONT  = 3'd1;
    localparam logic [2:0] CFG_H_ACTIVE = 3'd2;
    localparam logic [2:0] CFG_H_BACK   = 3'd3;
    localparam logic [2:0] CFG_V_SYNC   = 3'd4;
    localparam logic [2:0] CFG_V_FRONT  = 3'd5;
    localparam logic [2:0] CFG_V_ACTIVE = 3'd6;
    localparam logic [2:0] CFG_V_BACK   = 3'd7;

    // Preset sets, ordered H sync/front/active/back then V sync/front/active/back
    localparam logic [VMC_WIDTH-1:0] MODE0_TIMING [NUM_FIELDS] =
        '{11'd96, 11'd16, 11'd640, 11'd48, 11'd2, 11'd10, 11'd480, 11'd33};
    localparam logic [VMC_WIDTH-1:0] MODE1_TIMING [NUM_FIELDS] =
        '{11'd128, 11'd40, 11'd800, 11'd88, 11'd4, 11'd1, 11'd600, 11'd23};
    localparam logic [VMC_WIDTH-1:0] MODE2_TIMING [NUM_FIELDS] =
        '{11'd96, 11'd16, 11'd640, 11'd48, 11'd2, 11'd12, 11'd400, 11'd35};

    // Preset value of one field; anything that is not mode 1 or 2 falls back to mode 0
    function automatic logic [VMC_WIDTH-1:0] preset_field(input logic [1:0] mode,
                                                          input logic [2:0] field);
        logic [VMC_WIDTH-1:0] t [NUM_FIELDS];
        case (mode)
            MODE_800X600: t = MODE1_TIMING;
            MODE_640X400: t = MODE2_TIMING;
            default:      t = MODE0_TIMING;
        endcase
        return t[field];
    endfunction

endpackage

// File: rtl/vmc_edge_detect.sv
// rtl/vmc_edge_detect.sv - single-cycle pulse on the rising edge of a level input
module vmc_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level_d;

    // Remember the previous level so a held-high input fires only once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= i_level;
        end
    end

    assign o_pulse = i_level & ~r_level_d;

endmodule

// File: rtl/video_mode_controller.sv
// rtl/video_mode_controller.sv - frame-synchronous video mode switcher; CUSTOM_MODE_EN adds the mode 3 register file
module video_mode_controller
    import vmc_pkg::*;
#(
    parameter int WIDTH         = 11,
    parameter int SETTLE_FRAMES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LineEnd,
    input  logic             FrameEnd,
    input  logic [1:0]       ModeSel,
    input  logic             ModeReq,
    output logic             ModeAck,
    output logic [1:0]       CurMode,
    output logic             Busy,
    output logic             VideoEnable,
    output logic [WIDTH-1:0] HSynch,
    output logic [WIDTH-1:0] HFront,
    output logic [WIDTH-1:0] HActive,
    output logic [WIDTH-1:0] HBack,
    output logic [WIDTH-1:0] VSynch,
    output logic [WIDTH-1:0] VFront,
    output logic [WIDTH-1:0] VActive,
    output logic [WIDTH-1:0] VBack
`ifdef CUSTOM_MODE_EN
    ,
    input  logic             CfgWe,
    input  logic [2:0]       CfgAddr,
    input  logic [WIDTH-1:0] CfgData
`endif
);

    localparam int CNT_W = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_pending;
    logic [1:0]       r_cur_mode;
    logic             r_ack;
    logic             r_video_en;
    logic [WIDTH-1:0] r_timing     [NUM_FIELDS];
    logic [WIDTH-1:0] w_new_timing [NUM_FIELDS];

    logic       w_boundary;
    logic       w_req_ok;
    logic [1:0] w_sel_mode;
    logic       w_is_change;
    logic       w_accept;
    logic       w_latch;
    logic       w_apply;
    logic       w_dec;
    logic       w_finish;

    vmc_edge_detect u_frame_edge (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_level (LineEnd & FrameEnd),
        .o_pulse (w_boundary)
    );

    // A request is serviced only once; the cycle carrying the ack ignores the still-high request
    assign w_req_ok = ModeReq & ~r_ack;

`ifdef CUSTOM_MODE_EN
    logic [WIDTH-1:0] r_custom [NUM_FIELDS];

    // Custom register file, starting from the mode 0 set
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                r_custom[i] <= WIDTH'(preset_field(MODE_640X480, 3'(i)));
            end
        end else if (CfgWe) begin
            r_custom[CfgAddr] <= CfgData;
        end
    end

    assign w_sel_mode  = ModeSel;
    // Re-requesting mode 3 must pick up fresh register contents, so it always counts as a change
    assign w_is_change = (w_sel_mode != r_cur_mode) || (w_sel_mode == MODE_CUSTOM);
`else
    assign w_sel_mode  = (ModeSel == MODE_CUSTOM) ? MODE_640X480 : ModeSel;
    assign w_is_change = (w_sel_mode != r_cur_mode);
`endif

    // Timing set that the pending mode resolves to
    always_comb begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
            w_new_timing[i] = WIDTH'(preset_field(r_pending, 3'(i)));
`ifdef CUSTOM_MODE_EN
            if (r_pending == MODE_CUSTOM) begin
                w_new_timing[i] = r_custom[i];
            end
`endif
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and datapath controls; a boundary in PENDING outranks a new request
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_latch      = 1'b0;
        w_apply      = 1'b0;
        w_dec        = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_req_ok) begin
                    w_accept = 1'b1;
                    if (w_is_change) begin
                        w_latch      = 1'b1;
                        w_next_state = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (w_boundary) begin
                    w_apply      = 1'b1;
                    w_next_state = ST_SETTLE;
                end else if (w_req_ok) begin
                    w_accept = 1'b1;
                    w_latch  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_RUN;
                end else if (w_boundary) begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_SETTLE;
            end
        endcase
    end

    // Handshake, pending mode, settle counter, and the live timing set
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ack      <= 1'b0;
            r_pending  <= MODE_640X480;
            r_cur_mode <= MODE_640X480;
            r_video_en <= 1'b0;
            r_cnt      <= CNT_W'(SETTLE_FRAMES);
            for (int i = 0; i < NUM_FIELDS; i++) begin
                r_timing[i] <= WIDTH'(preset_field(MODE_640X480, 3'(i)));
            end
        end else begin
            r_ack <= w_accept;
            if (w_latch) begin
                r_pending <= w_sel_mode;
            end
            if (w_apply) begin
                r_cur_mode <= r_pending;
                r_video_en <= 1'b0;
                r_cnt      <= CNT_W'(SETTLE_FRAMES);
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    r_timing[i] <= w_new_timing[i];
                end
            end else if (w_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_video_en <= 1'b1;
            end
        end
    end

    assign ModeAck     = r_ack;
    assign CurMode     = r_cur_mode;
    assign Busy        = (r_state != ST_RUN);
    assign VideoEnable = r_video_en;
    assign HSynch      = r_timing[CFG_H_SYNC];
    assign HFront      = r_timing[CFG_H_FRONT];
    assign HActive     = r_timing[CFG_H_ACTIVE];
    assign HBack       = r_timing[CFG_H_BACK];
    assign VSynch      = r_timing[CFG_V_SYNC];
    assign VFront      = r_timing[CFG_V_FRONT];
    assign VActive     = r_timing[CFG_V_ACTIVE];
    assign VBack       = r_timing[CFG_V_BACK];

endmodule

// File: tb/tb_video_mode_controller.sv
// tb/tb_video_mode_controller.sv - scoreboard bench for video_mode_controller
module tb_video_mode_controller;

    localparam int W = 11;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         LineEnd = 1'b0;
    logic         FrameEnd = 1'b0;
    logic [1:0]   ModeSel = 2'd0;
    logic         ModeReq = 1'b0;
    logic         ModeAck;
    logic [1:0]   CurMode;
    logic         Busy;
    logic         VideoEnable;
    logic [W-1:0] HSynch, HFront, HActive, HBack;
    logic [W-1:0] VSynch, VFront, VActive, VBack;
`ifdef CUSTOM_MODE_EN
    logic         CfgWe = 1'b0;
    logic [2:0]   CfgAddr = 3'd0;
    logic [W-1:0] CfgData = '0;
`endif

    video_mode_controller dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .LineEnd     (LineEnd),
        .FrameEnd    (FrameEnd),
        .ModeSel     (ModeSel),
        .ModeReq     (ModeReq),
        .ModeAck     (ModeAck),
        .CurMode     (CurMode),
        .Busy        (Busy),
        .VideoEnable (VideoEnable),
        .HSynch      (HSynch),
        .HFront      (HFront),
        .HActive     (HActive),
        .HBack       (HBack),
        .VSynch      (VSynch),
        .VFront      (VFront),
        .VActive     (VActive),
        .VBack       (VBack)
`ifdef CUSTOM_MODE_EN
        ,
        .CfgWe       (CfgWe),
        .CfgAddr     (CfgAddr),
        .CfgData     (CfgData)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]   cur;
        logic [W-1:0] hs, hf, ha, hb, vs, vf, va, vb;
        logic         ve;
        logic         busy;
    } snap_t;

    typedef struct packed {
        logic busy;
        logic ve;
    } ack_t;

    snap_t        exp_q[$];
    ack_t         ack_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] custom_ha = 11'd640;

    function automatic snap_t mk(input int mode, input logic ve, input logic busy);
        snap_t s;
        case (mode)
            1: s = {2'd1, 11'd128, 11'd40, 11'd800, 11'd88, 11'd4, 11'd1, 11'd600, 11'd23, ve, busy};
            2: s = {2'd2, 11'd96, 11'd16, 11'd640, 11'd48, 11'd2, 11'd12, 11'd400, 11'd35, ve, busy};
`ifdef CUSTOM_MODE_EN
            3: s = {2'd3, 11'd96, 11'd16, custom_ha, 11'd48, 11'd2, 11'd10, 11'd480, 11'd33, ve, busy};
`else
            3: s = {2'd0, 11'd96, 11'd16, 11'd640, 11'd48, 11'd2, 11'd10, 11'd480, 11'd33, ve, busy};
`endif
            default: s = {2'd0, 11'd96, 11'd16, 11'd640, 11'd48, 11'd2, 11'd10, 11'd480, 11'd33, ve, busy};
        endcase
        return s;
    endfunction

    // Monitor: every change of the output set and every ack is checked against the queues
    snap_t last_snap;
    bit    have_last = 1'b0;
    logic  prev_ack = 1'b0;
    always @(negedge CLK) begin
        snap_t cur_s;
        snap_t e;
        ack_t  a;
        cur_s = {CurMode, HSynch, HFront, HActive, HBack, VSynch, VFront, VActive, VBack,
                 VideoEnable, Busy};
        if (!have_last || cur_s != last_snap) begin
            have_last = 1'b1;
            last_snap = cur_s;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL snapshot: unexpected change cur=%0d ha=%0d va=%0d ve=%0b busy=%0b",
                         cur_s.cur, cur_s.ha, cur_s.va, cur_s.ve, cur_s.busy);
            end else begin
                e = exp_q.pop_front();
                if (cur_s !== e) begin
                    errors++;
                    $display("FAIL snapshot: got cur=%0d ha=%0d vf=%0d va=%0d ve=%0b busy=%0b raw=%h, want cur=%0d ha=%0d vf=%0d va=%0d ve=%0b busy=%0b raw=%h",
                             cur_s.cur, cur_s.ha, cur_s.vf, cur_s.va, cur_s.ve, cur_s.busy, cur_s,
                             e.cur, e.ha, e.vf, e.va, e.ve, e.busy, e);
                end
            end
        end
        if (ModeAck === 1'b1) begin
            checks++;
            if (prev_ack === 1'b1) begin
                errors++;
                $display("FAIL ack_width: ModeAck high on two consecutive cycles");
            end else if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack: unexpected ModeAck busy=%0b ve=%0b", Busy, VideoEnable);
            end else begin
                a = ack_q.pop_front();
                if (Busy !== a.busy || VideoEnable !== a.ve) begin
                    errors++;
                    $display("FAIL ack_state: got busy=%0b ve=%0b, want busy=%0b ve=%0b",
                             Busy, VideoEnable, a.busy, a.ve);
                end
            end
        end
        prev_ack = ModeAck;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame(input int hold);
        @(negedge CLK);
        LineEnd  = 1'b1;
        FrameEnd = 1'b1;
        repeat (hold) @(negedge CLK);
        LineEnd  = 1'b0;
        FrameEnd = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic settle();
        repeat (4) frame(1);
        tick(2);
    endtask

    task automatic request(input logic [1:0] sel);
        int n;
        @(negedge CLK);
        ModeSel = sel;
        ModeReq = 1'b1;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (ModeAck !== 1'b1 && n < 200);
        if (ModeAck !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ModeAck for ModeSel=%0d within %0d cycles", sel, n);
        end
        @(posedge CLK);
        #1;
        ModeReq = 1'b0;
    endtask

    initial begin
        exp_q.push_back(mk(0, 1'b0, 1'b1));
        tick(2);
        chk("rst_hactive", int'(HActive), 640);
        chk("rst_vback", int'(VBack), 33);
        chk("rst_curmode", int'(CurMode), 0);
        chk("rst_ack", int'(ModeAck), 0);
        chk("rst_ve", int'(VideoEnable), 0);
        chk("rst_busy", int'(Busy), 1);
        RESET = 1'b1;
        tick(2);

        // Three boundaries, one of them a level held five cycles
        frame(1);
        frame(5);
        frame(1);
        chk("settle3_ve", int'(VideoEnable), 0);
        chk("settle3_busy", int'(Busy), 1);
        // LineEnd or FrameEnd alone is not a boundary
        @(negedge CLK);
        LineEnd = 1'b1;
        tick(3);
        LineEnd  = 1'b0;
        FrameEnd = 1'b1;
        tick(3);
        FrameEnd = 1'b0;
        tick(3);
        chk("lone_edge_ve", int'(VideoEnable), 0);
        exp_q.push_back(mk(0, 1'b1, 1'b0));
        frame(1);
        chk("settle4_ve", int'(VideoEnable), 1);

        // Same-mode request is acked but changes nothing
        ack_q.push_back('{busy: 1'b0, ve: 1'b1});
        request(2'd0);
        tick(2);

        // Mode 1: outputs hold until the boundary
        exp_q.push_back(mk(0, 1'b1, 1'b1));
        ack_q.push_back('{busy: 1'b1, ve: 1'b1});
        request(2'd1);
        tick(3);
        chk("pend_hactive", int'(HActive), 640);
        chk("pend_curmode", int'(CurMode), 0);
        exp_q.push_back(mk(1, 1'b0, 1'b1));
        frame(1);
        chk("m1_hactive", int'(HActive), 800);
        chk("m1_hback", int'(HBack), 88);
        chk("m1_vactive", int'(VActive), 600);
        chk("m1_curmode", int'(CurMode), 1);
        chk("m1_ve", int'(VideoEnable), 0);
        exp_q.push_back(mk(1, 1'b1, 1'b0));
        settle();

        // Back to mode 0
        exp_q.push_back(mk(1, 1'b1, 1'b1));
        ack_q.push_back('{busy: 1'b1, ve: 1'b1});
        request(2'd0);
        exp_q.push_back(mk(0, 1'b0, 1'b1));
        frame(1);
        exp_q.push_back(mk(0, 1'b1, 1'b0));
        settle();

        // Pending mode 1 overwritten by mode 2 before the boundary
        exp_q.push_back(mk(0, 1'b1, 1'b1));
        ack_q.push_back('{busy: 1'b1, ve: 1'b1});
        request(2'd1);
        ack_q.push_back('{busy: 1'b1, ve: 1'b1});
        request(2'd2);
        exp_q.push_back(mk(2, 1'b0, 1'b1));
        frame(1);
        chk("m2_vactive", int'(VActive), 400);
        chk("m2_vfront", int'(VFront), 12);
        chk("m2_curmode", int'(CurMode), 2);

        // Request during SETTLE is acked only once RUN is reached
        exp_q.push_back(mk(2, 1'b1, 1'b0));
        exp_q.push_back(mk(2, 1'b1, 1'b1));
        ack_q.push_back('{busy: 1'b1, ve: 1'b1});
        fork
            request(2'd1);
            settle();
        join
        tick(2);
        exp_q.push_back(mk(1, 1'b0, 1'b1));
        frame(1);
        exp_q.push_back(mk(1, 1'b1, 1'b0));
        settle();

        // Mode 3: custom set with the macro, mode 0 without it
`ifdef CUSTOM_MODE_EN
        @(negedge CLK);
        CfgWe   = 1'b1;
        CfgAddr = 3'd2;
        CfgData = 11'd720;
        @(negedge CLK);
        CfgWe   = 1'b0;
        custom_ha = 11'd720;
`endif
        exp_q.push_back(mk(1, 1'b1, 1'b1));
        ack_q.push_back('{busy: 1'b1, ve: 1'b1});
        request(2'd3);
        exp_q.push_back(mk(3, 1'b0, 1'b1));
        frame(1);
        chk("m3_hactive", int'(HActive), int'(custom_ha));
        exp_q.push_back(mk(3, 1'b1, 1'b0));
        settle();

        tick(5);
        chk("snap_queue_left", exp_q.size(), 0);
        chk("ack_queue_left", ack_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_mode_controller.md
Name: video_mode_controller

Overview:
- Sequences and configures the horizontal and vertical sync timing generators.
- Holds the active timing set: synch pulse, front porch, active video and back porch for both H and V.
- Accepts mode-change requests through a req/ack handshake and applies a new set only on a frame boundary, so no partial frame is produced.
- Blanks video for a programmable number of frames after reset and after every mode change, so the monitor can resync.

Parameters:
- WIDTH, 11: width of every timing field. 11 bits are needed because an 800x600 horizontal total is 1056.
- SETTLE_FRAMES, 4: number of whole frames that VideoEnable stays low after reset or after a mode change.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- LineEnd  in  1  end-of-line indication from the H timing generator. A level; it may last several cycles.
- FrameEnd  in  1  last-line indication from the V timing generator.
- ModeSel  in  2  requested mode.
- ModeReq  in  1  request. Held high until ModeAck is seen.
- ModeAck  out  1  one-cycle acknowledge.
- CurMode  out  2  mode currently driven.
- Busy  out  1  high while a change is pending or the block is settling.
- VideoEnable  out  1  gates pixel output.
- HSynch, HFront, HActive, HBack  out  WIDTH each  horizontal timing values.
- VSynch, VFront, VActive, VBack  out  WIDTH each  vertical timing values.
- CfgWe  in  1  custom-mode write enable (macro only).
- CfgAddr  in  3  custom-mode field select (macro only).
- CfgData  in  WIDTH  custom-mode field value (macro only).

Behaviour:
- Mode table (H sync/front/active/back; V sync/front/active/back):
  - Mode 0 (640x480): H 96/16/640/48; V 2/10/480/33.
  - Mode 1 (800x600): H 128/40/800/88; V 4/1/600/23.
  - Mode 2 (640x400): H 96/16/640/48; V 2/12/400/35.
  - Mode 3: custom mode (see Optional Feature).
- Frame boundary: the rising edge of (LineEnd & FrameEnd) gives exactly one internal event per frame. A level held high does not re-trigger.
- Reset values:
  - Outputs: timing = mode 0, CurMode = 0, ModeAck = 0, VideoEnable = 0, Busy = 1.
  - FSM: state SETTLE, frame counter = SETTLE_FRAMES.
- FSM states: RUN, PENDING, SETTLE.
- RUN:
  - ModeReq high: assert ModeAck the next cycle.
  - If ModeSel equals CurMode, stay in RUN (no-op).
  - Otherwise latch ModeSel into the pending register, go to PENDING and set Busy = 1.
- PENDING:
  - On a frame-boundary event: load the pending mode into all timing outputs and CurMode in the same cycle. Set VideoEnable = 0, load counter = SETTLE_FRAMES, go to SETTLE.
  - A new ModeReq arriving without a boundary event is acked and overwrites the pending register.
  - If a ModeReq and a boundary event occur in the same cycle, the boundary wins. The request gets no ack that cycle and is held off until RUN.
- SETTLE:
  - Each boundary event decrements the counter. When the counter is 0, go to RUN on the next cycle with VideoEnable = 1 and Busy = 0.
  - With SETTLE_FRAMES = 0, go to RUN the cycle after entry.
  - No acks are issued in SETTLE; the requester keeps waiting.
- Timing outputs change only on a boundary event and are registered (one-cycle latency from the event).
- Reset mid-change: the pending mode is discarded and mode 0 is restored.
- ModeAck is never asserted on two consecutive cycles. The requester must drop ModeReq on the cycle after the ack.

Optional Feature:
- Macro CUSTOM_MODE_EN.
- When defined:
  - Mode 3 reads an 8-entry custom register file written via CfgWe/CfgAddr/CfgData. Addresses 0–3 hold HSynch/HFront/HActive/HBack; addresses 4–7 hold VSynch/VFront/VActive/VBack.
  - The file resets to mode-0 values.
  - Writes take effect only when mode 3 is next applied at a boundary. If mode 3 is already current, a re-request of mode 3 is treated as a change and goes through PENDING.
- When undefined:
  - The Cfg* ports are absent.
  - ModeSel = 3 is treated as mode 0.

Decomposition:
- Package vmc_pkg holds:
  - the mode encodings;
  - the preset timing constants for modes 0–2;
  - the FSM state encoding;
  - the custom-register address constants.
- One natural sub-module, vmc_edge_detect: registers its input and produces a single-cycle pulse on the rising edge; it is used for the frame-boundary event.

Test Plan:
- Reset release, SETTLE_FRAMES = 4 → timing outputs = mode 0 (HActive = 640, VBack = 33). VideoEnable goes high only after the 4th boundary event; Busy then falls.
- In RUN, ModeReq with ModeSel = 1 → ModeAck for one cycle, Busy = 1, outputs unchanged until the next boundary. At the boundary, HActive = 800, HBack = 88, VActive = 600, CurMode = 1, VideoEnable = 0.
- While PENDING with mode 1 latched, request mode 2 → acked. The next boundary applies VActive = 400 and VFront = 12; mode 1 is never driven.
- Request issued during SETTLE → no ack until RUN. The first cycle in RUN acks it and it is then processed normally.
- LineEnd & FrameEnd held high for 5 cycles → counts as exactly one boundary event (settle counter decrements by 1).
- With CUSTOM_MODE_EN: write HActive = 720 at address 2, then request mode 3 → HActive = 720 after the boundary. Without the macro, request mode 3 → CurMode = 0 values.
